pe_mac_seq: RTL
===============

# pe_mac_seq

Sequencer on the initiator side of a single MAC processing element (PE). It accepts one dot-product job (length `len`) and pulls `len` IFM/weight pairs from a valid/ready input stream. It drives the PE's clear/operand/finish inputs through a registered operand stage, captures the PE result when the PE raises `valid`, and holds it on a valid/ready result port until downstream accepts it. It sits between the line/weight buffers and each PE in the fused-block datapath.

## Interface
Parameters:
- `DATA_W`, 8 — IFM/weight/OFM width; must match the PE.
- `LEN_W`, 5 — width of the job length field; maximum job length is 2^LEN_W − 1.

Ports (reset `reset_n`, asynchronous, active-low; clock `clk`):
- `clk` in 1 — clock.
- `reset_n` in 1 — asynchronous active-low reset.
- `start` in 1 — job request; sampled only in IDLE.
- `len` in LEN_W — number of pairs; sampled with `start`.
- `busy` out 1 — high in every state except IDLE.
- `in_valid` in 1 — input pair valid.
- `in_ready` out 1 — input pair ready.
- `in_ifm` in DATA_W — input IFM operand.
- `in_wei` in DATA_W — input weight operand.
- `pe_ifm` out DATA_W — registered operand to PE.
- `pe_wei` out DATA_W — registered operand to PE.
- `pe_en` out 1 — registered PE accumulator clear, active high.
- `pe_finish` out 1 — registered PE finish strobe.
- `pe_ofm` in DATA_W — PE accumulator value.
- `pe_valid` in 1 — PE result valid; arrives one cycle after `pe_finish`.
- `res_valid` out 1 — result valid.
- `res_ready` in 1 — result ready.
- `res_data` out DATA_W — captured dot product.

## Operation
- PE contract:
  - `pe_en`=1 clears the accumulator at the next edge.
  - `pe_en`=0 adds `pe_ifm*pe_wei` (DATA_W-bit truncated product) at each edge.
- Operand stage register: {`pe_ifm`, `pe_wei`, `pe_en`, `pe_finish`}, loaded every cycle from the FSM.
  - Default load (no handshake): ifm=0, wei=0, finish=0; en=1 in IDLE/WAIT/HOLD, en=0 in FEED.
  - Zero operands during FEED stalls leave the accumulator unchanged.
- States:
  - IDLE:
    - `in_ready`=0.
    - `start`&&`len`≠0 → FEED; load count=`len`.
    - `start`&&`len`==0 → HOLD with `res_data`=0; no input consumed and no PE activity.
  - FEED:
    - `in_ready`=1.
    - On each handshake, load stage with {in_ifm, in_wei, en=0, finish=(count==1)} and decrement count.
    - Handshake with count==1 → WAIT.
  - WAIT:
    - `in_ready`=0.
    - On `pe_valid`, capture `pe_ofm` into `res_data`, set `res_valid`, and go to HOLD.
  - HOLD:
    - `res_valid`=1.
    - `res_valid`&&`res_ready` → IDLE and clear `res_valid`.
- `start` in any state other than IDLE is ignored.
- Arithmetic is DATA_W-bit modular end to end; the block does not alter data.
- Mid-operation reset: return to IDLE and drop the job; no partial result is produced.

## Timing
- Reset values:
  - state=IDLE, `busy`=0, `in_ready`=0.
  - `pe_ifm`=0, `pe_wei`=0, `pe_en`=1, `pe_finish`=0.
  - `res_valid`=0, `res_data`=0.
- Cycle 0 is the cycle in which `start` is accepted. With `len`=N and no stalls:
  - Handshakes occur in cycles 1..N.
  - PE accumulates in cycles 2..N+1.
  - `pe_finish` is high in cycle N+1.
  - `pe_valid` is high in cycle N+2.
  - `res_valid` rises in cycle N+3.
- Each stall cycle in FEED adds exactly one cycle of latency.
- With `res_ready` held high, the next `start` is accepted in cycle N+4 (one job per N+4 cycles).
- Accumulator clear: in the cycle after accept, the stage still carries `pe_en`=1, so the accumulator is zero before the first operand.
- The WAIT-state `pe_en`=1 takes effect in cycle N+2, so `pe_ofm` is stable while `pe_valid` is high.
- `res_data` is stable while `res_valid`=1.

## Configuration
- `PE_MAC_SEQ_PERF_EN` defined: adds two 16-bit saturating output counters.
  - `perf_jobs`: incremented on each HOLD→IDLE transition.
  - `perf_stalls`: incremented on each FEED cycle with `in_valid`=0.
  - Both counters reset to 0.
- `PE_MAC_SEQ_PERF_EN` undefined: the ports and logic are absent; the function of the block is otherwise identical.

## Structure
- Shared package `pe_pkg`:
  - `DATA_W`, `LEN_W` defaults.
  - `pe_seq_state_t` enum {IDLE, FEED, WAIT, HOLD}.
  - `pe_op_t` struct {ifm, wei, en, finish}.
- One natural sub-module, `pe_op_stage`: the registered PE-operand stage, with reset value {0, 0, 1, 0}.
- The PE itself is instantiated by the parent, not inside this block.

## Test plan
- Reset mid-FEED (after 1 of 3 pairs) → the following job `len`=1, (9,9) gives `res_data`=81. No stale accumulation.
- `len`=3, pairs (2,3),(4,5),(1,7), no stalls → `res_data`=33, `res_valid` rises 6 cycles after the `start` cycle.
- `len`=2, pairs (20,20),(10,12) → `res_data`=8 (144+120 mod 256).
- `len`=2, pairs (5,5),(3,3) with `in_valid` low for 2 cycles between the pairs → `res_data`=34, latency +2; `perf_stalls`=2 with `PE_MAC_SEQ_PERF_EN`.
- `len`=0 → `res_valid` in cycle 1 with `res_data`=0; `in_ready` never high; `pe_en` stays 1.
- `res_ready` low for 5 cycles in HOLD, `start` pulsed during HOLD → result held stable and `start` ignored. `busy` falls one cycle after acceptance.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE MAC sequencer and its operand stage.
package pe_pkg;

    localparam int PE_DATA_W = 8;
    localparam int PE_LEN_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } pe_seq_state_t;

    // Everything the PE sees on one edge: operands, clear, finish strobe.
    typedef struct packed {
        logic [PE_DATA_W-1:0] ifm;
        logic [PE_DATA_W-1:0] wei;
        logic                 en;
        logic                 finish;
    } pe_op_t;

endpackage

// File: rtl/pe_op_stage.sv
// Registered PE operand stage. Resets to a clearing, non-finishing,
// zero-operand word so the PE accumulator is held at zero out of reset.
module pe_op_stage
    import pe_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  pe_op_t op_d,
    output pe_op_t op_q
);

    // Load the next operand word every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q.ifm    <= '0;
            op_q.wei    <= '0;
            op_q.en     <= 1'b1;
            op_q.finish <= 1'b0;
        end else begin
            op_q <= op_d;
        end
    end

endmodule

// File: rtl/pe_mac_seq.sv
// Initiator-side sequencer for one MAC PE: accepts a dot-product job,
// streams len operand pairs into the PE, captures and presents the result.
// Optional feature macro: PE_MAC_SEQ_PERF_EN adds perf_jobs / perf_stalls.
// DATA_W must equal pe_pkg::PE_DATA_W (the operand struct is sized by it).
//
// state | meaning
// IDLE  | waiting for start; PE held cleared
// FEED  | accepting operand pairs, count = pairs still to take
// WAIT  | last pair issued, waiting for PE result valid
// HOLD  | result presented on res_* until accepted
module pe_mac_seq
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int LEN_W  = PE_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_ifm,
    input  logic [DATA_W-1:0] in_wei,
    output logic [DATA_W-1:0] pe_ifm,
    output logic [DATA_W-1:0] pe_wei,
    output logic              pe_en,
    output logic              pe_finish,
    input  logic [DATA_W-1:0] pe_ofm,
    input  logic              pe_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data
`ifdef PE_MAC_SEQ_PERF_EN
    ,
    output logic [15:0]       perf_jobs,
    output logic [15:0]       perf_stalls
`endif
);

    pe_seq_state_t    state_q, state_nx;
    logic [LEN_W-1:0] count_q;
    pe_op_t           op_d, op_q;

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == FEED);
    assign res_valid = (state_q == HOLD);

    // Next state and next operand word; zero operands during FEED stalls
    // leave the accumulator untouched.
    always_comb begin
        state_nx    = state_q;
        op_d.ifm    = '0;
        op_d.wei    = '0;
        op_d.en     = (state_q != FEED);
        op_d.finish = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nx = (len != '0) ? FEED : HOLD;
                end
            end
            FEED: begin
                if (in_valid) begin
                    op_d.ifm    = in_ifm;
                    op_d.wei    = in_wei;
                    op_d.en     = 1'b0;
                    op_d.finish = (count_q == LEN_W'(1));
                    if (count_q == LEN_W'(1)) begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (pe_valid) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, remaining-pair down-counter and result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            res_data <= '0;
        end else begin
            state_q <= state_nx;
            if (state_q == IDLE && start) begin
                count_q <= len;
                if (len == '0) begin
                    res_data <= '0;
                end
            end else if (state_q == FEED && in_valid) begin
                count_q <= count_q - LEN_W'(1);
            end
            if (state_q == WAIT && pe_valid) begin
                res_data <= pe_ofm;
            end
        end
    end

    pe_op_stage u_op_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .op_d    (op_d),
        .op_q    (op_q)
    );

    assign pe_ifm    = op_q.ifm;
    assign pe_wei    = op_q.wei;
    assign pe_en     = op_q.en;
    assign pe_finish = op_q.finish;

`ifdef PE_MAC_SEQ_PERF_EN
    // Saturating job and input-stall counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_jobs   <= '0;
            perf_stalls <= '0;
        end else begin
            if (state_q == HOLD && res_ready && perf_jobs != 16'hFFFF) begin
                perf_jobs <= perf_jobs + 16'd1;
            end
            if (state_q == FEED && !in_valid && perf_stalls != 16'hFFFF) begin
                perf_stalls <= perf_stalls + 16'd1;
            end
        end
    end
`endif

endmodule
